// File: rtl/bcd_temp_display.sv
// bcd_temp_display
//    Converts a signed temperature in tenths of a degree (-99.9 .. +99.9)
//    into four seven_seg digit codes: sign, tens, units, tenths. The
//    conversion is a sequential double-dabble (10 shift cycles plus one
//    format cycle). The digit outputs and ovf change together, only when a
//    conversion completes.
//
// Ports
//    clk      : single clock, rising edge
//    rst      : asynchronous active-low reset
//    value    : 11-bit signed temperature in tenths of a degree
//    start    : conversion request, sampled only while idle
//    busy     : conversion in progress
//    done     : one-cycle pulse, new digits valid
//    ovf      : last converted magnitude exceeded 999 and was clamped
//    digit_0  : tenths
//    digit_1  : units
//    digit_2  : tens, or OFF_CODE when blanked
//    digit_3  : sign, NEG_CODE or OFF_CODE
module bcd_temp_display #(
   parameter logic [3:0] OFF_CODE   = 4'hA,
   parameter logic [3:0] NEG_CODE   = 4'hB,
   parameter bit         BLANK_LEAD = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] value,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [3:0]  digit_0,
   output logic [3:0]  digit_1,
   output logic [3:0]  digit_2,
   output logic [3:0]  digit_3
);

   typedef enum logic [1:0] {IDLE, SHIFT, FMT} state_t;

   state_t       state_reg, state_next;
   logic [3:0]   cnt_reg, cnt_next;
   // [21:10] BCD hundreds/tens/ones, [9:0] binary magnitude being shifted out
   logic [21:0]  work_reg, work_next;
   logic         sign_reg, sign_next;
   logic         ovf_pend_reg, ovf_pend_next;
   logic         ovf_reg, ovf_next;
   logic         done_reg, done_next;
   logic [3:0]   d0_reg, d0_next;
   logic [3:0]   d1_reg, d1_next;
   logic [3:0]   d2_reg, d2_next;
   logic [3:0]   d3_reg, d3_next;

   // Magnitude at 11 bits so that -1024 becomes 1024 and is then clamped.
   logic [10:0]  mag_full;
   logic [9:0]   mag_clamped;
   logic         mag_over;

   assign mag_full    = value[10] ? (~value + 11'd1) : value;
   assign mag_over    = (mag_full > 11'd999);
   assign mag_clamped = mag_over ? 10'd999 : mag_full[9:0];

   // Double-dabble add-3 correction on each BCD nibble before the shift.
   logic [21:0]  work_adj;

   assign work_adj[9:0] = work_reg[9:0];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_adj
         logic [3:0] nib;
         assign nib = work_reg[10 + 4*gi +: 4];
         assign work_adj[10 + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
      end
   endgenerate

   // State and datapath register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= 4'd0;
         work_reg     <= 22'd0;
         sign_reg     <= 1'b0;
         ovf_pend_reg <= 1'b0;
         ovf_reg      <= 1'b0;
         done_reg     <= 1'b0;
         d0_reg       <= 4'd0;
         d1_reg       <= 4'd0;
         d2_reg       <= OFF_CODE;
         d3_reg       <= OFF_CODE;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         work_reg     <= work_next;
         sign_reg     <= sign_next;
         ovf_pend_reg <= ovf_pend_next;
         ovf_reg      <= ovf_next;
         done_reg     <= done_next;
         d0_reg       <= d0_next;
         d1_reg       <= d1_next;
         d2_reg       <= d2_next;
         d3_reg       <= d3_next;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      work_next     = work_reg;
      sign_next     = sign_reg;
      ovf_pend_next = ovf_pend_reg;
      ovf_next      = ovf_reg;
      done_next     = 1'b0;
      d0_next       = d0_reg;
      d1_next       = d1_reg;
      d2_next       = d2_reg;
      d3_next       = d3_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               work_next     = {12'd0, mag_clamped};
               sign_next     = value[10];
               ovf_pend_next = mag_over;
               cnt_next      = 4'd0;
               state_next    = SHIFT;
            end
         end
         SHIFT: begin
            work_next = work_adj << 1;
            cnt_next  = cnt_reg + 4'd1;
            if (cnt_reg == 4'd9) begin
               state_next = FMT;
            end
         end
         FMT: begin
            d0_next = work_reg[13:10];
            d1_next = work_reg[17:14];
            if (BLANK_LEAD && (work_reg[21:18] == 4'd0)) begin
               d2_next = OFF_CODE;
            end else begin
               d2_next = work_reg[21:18];
            end
            // A negative value always has nonzero magnitude, so no -0 case.
            d3_next    = sign_reg ? NEG_CODE : OFF_CODE;
            ovf_next   = ovf_pend_reg;
            done_next  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      busy    = (state_reg != IDLE);
      done    = done_reg;
      ovf     = ovf_reg;
      digit_0 = d0_reg;
      digit_1 = d1_reg;
      digit_2 = d2_reg;
      digit_3 = d3_reg;
   end

endmodule

// File: tb/tb_bcd_temp_display.sv
// Testbench for bcd_temp_display: table of hand-derived vectors, random
// values against an arithmetic reference model, and hand-written timing,
// start-while-busy, held-start and reset-mid-conversion sequences. Two
// instances run in lockstep: default blanking and BLANK_LEAD=0.
module tb_bcd_temp_display;

   logic        clk;
   logic        rst;
   logic [10:0] value;
   logic        start;

   logic        busy_a, done_a, ovf_a;
   logic [3:0]  d0_a, d1_a, d2_a, d3_a;
   logic        busy_b, done_b, ovf_b;
   logic [3:0]  d0_b, d1_b, d2_b, d3_b;

   int tests;
   int fails;

   bcd_temp_display dut_a (
      .clk(clk), .rst(rst), .value(value), .start(start),
      .busy(busy_a), .done(done_a), .ovf(ovf_a),
      .digit_0(d0_a), .digit_1(d1_a), .digit_2(d2_a), .digit_3(d3_a)
   );

   bcd_temp_display #(.BLANK_LEAD(1'b0)) dut_b (
      .clk(clk), .rst(rst), .value(value), .start(start),
      .busy(busy_b), .done(done_b), .ovf(ovf_b),
      .digit_0(d0_b), .digit_1(d1_b), .digit_2(d2_b), .digit_3(d3_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] v;
      logic [15:0] exp_digits;   // {digit_3, digit_2, digit_1, digit_0}
      logic        exp_ovf;
   } vec_t;

   // Reference: plain decimal arithmetic on the signed value.
   function automatic void model(input logic [10:0] v, input bit blank,
                                 output logic [15:0] digits, output logic o);
      int s, m;
      logic [3:0] d3, d2, d1, d0;
      s = int'($signed(v));
      m = (s < 0) ? -s : s;
      o = (m > 999);
      if (o) m = 999;
      d0 = 4'(m % 10);
      d1 = 4'((m / 10) % 10);
      d2 = 4'(m / 100);
      if (blank && d2 == 4'd0) d2 = 4'hA;
      d3 = (s < 0) ? 4'hB : 4'hA;
      digits = {d3, d2, d1, d0};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string name, input logic [10:0] v);
      logic [15:0] ea, eb;
      logic oa, ob;
      model(v, 1'b1, ea, oa);
      model(v, 1'b0, eb, ob);
      chk({name, " digits_a"}, int'({d3_a, d2_a, d1_a, d0_a}), int'(ea));
      chk({name, " ovf_a"}, int'(ovf_a), int'(oa));
      chk({name, " digits_b"}, int'({d3_b, d2_b, d1_b, d0_b}), int'(eb));
      chk({name, " ovf_b"}, int'(ovf_b), int'(ob));
   endtask

   // Drive start for one sampling edge (edge N); returns #1 after edge N.
   task automatic pulse_start(input logic [10:0] v);
      @(negedge clk);
      value = v;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Cycles from edge N until done is seen; -1 if the bound expires.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done_a) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_case(input string name, input logic [10:0] v);
      int lat;
      pulse_start(v);
      wait_done(lat);
      chk({name, " latency"}, lat, 11);
      chk({name, " done_b"}, int'(done_b), 1);
      chk_outs(name, v);
      @(posedge clk);
      #1;
      chk({name, " done_fall"}, int'(done_a), 0);
      $display("[TB] %s value=%h digits=%h%h%h%h ovf=%0d", name, v,
               d3_a, d2_a, d1_a, d0_a, ovf_a);
   endtask

   vec_t vecs[12];

   initial begin
      int lat;
      int busy_cnt;
      logic [10:0] rv;

      tests = 0;
      fails = 0;
      rst   = 1'b0;
      start = 1'b0;
      value = 11'd0;

      vecs[0]  = '{11'd257,  16'hA257, 1'b0};
      vecs[1]  = '{11'h7D3,  16'hBA45, 1'b0};
      vecs[2]  = '{11'h400,  16'hB999, 1'b1};
      vecs[3]  = '{11'h3E8,  16'hA999, 1'b1};
      vecs[4]  = '{11'd5,    16'hAA05, 1'b0};
      vecs[5]  = '{11'd0,    16'hAA00, 1'b0};
      vecs[6]  = '{11'h3E7,  16'hA999, 1'b0};
      vecs[7]  = '{11'h419,  16'hB999, 1'b0};
      vecs[8]  = '{11'h7FF,  16'hBA01, 1'b0};
      vecs[9]  = '{11'd100,  16'hA100, 1'b0};
      vecs[10] = '{11'h3FF,  16'hA999, 1'b1};
      vecs[11] = '{11'h418,  16'hB999, 1'b1};

      // Reset, idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset digits_a", int'({d3_a, d2_a, d1_a, d0_a}), 16'hAA00);
      chk("reset digits_b", int'({d3_b, d2_b, d1_b, d0_b}), 16'hAA00);
      chk("reset busy", int'(busy_a), 0);
      chk("reset done", int'(done_a), 0);
      chk("reset ovf", int'(ovf_a), 0);
      $display("[TB] reset idle digits=%h%h%h%h", d3_a, d2_a, d1_a, d0_a);

      // Cycle-accurate +257: busy 11 cycles, done only at N+11, no early update
      pulse_start(11'd257);
      busy_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         if (busy_a) busy_cnt++;
         chk($sformatf("t257 done@%0d", k - 1), int'(done_a), 0);
         chk($sformatf("t257 hold@%0d", k - 1),
             int'({d3_a, d2_a, d1_a, d0_a}), 16'hAA00);
         if (k == 11) break;
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      chk("t257 busy cycles", busy_cnt, 11);
      chk("t257 busy low @11", int'(busy_a), 0);
      chk("t257 done @11", int'(done_a), 1);
      chk_outs("t257", 11'd257);
      @(posedge clk);
      #1;
      chk("t257 done fall @12", int'(done_a), 0);
      $display("[TB] t257 digits=%h%h%h%h busy_cycles=%0d",
               d3_a, d2_a, d1_a, d0_a, busy_cnt);

      // Table of hand-derived vectors
      foreach (vecs[i]) begin
         pulse_start(vecs[i].v);
         wait_done(lat);
         chk($sformatf("vec%0d latency", i), lat, 11);
         chk($sformatf("vec%0d digits", i),
             int'({d3_a, d2_a, d1_a, d0_a}), int'(vecs[i].exp_digits));
         chk($sformatf("vec%0d ovf", i), int'(ovf_a), int'(vecs[i].exp_ovf));
         chk_outs($sformatf("vec%0d", i), vecs[i].v);
         $display("[TB] vec%0d value=%h digits=%h%h%h%h ovf=%0d", i,
                  vecs[i].v, d3_a, d2_a, d1_a, d0_a, ovf_a);
      end

      // Random values against the model
      for (int i = 0; i < 24; i++) begin
         rv = 11'($urandom_range(0, 2047));
         run_case($sformatf("rand%0d", i), rv);
      end

      // Start pulse while busy is ignored
      pulse_start(11'd123);
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (k == 4) begin
            start = 1'b1;
            value = 11'h419;
         end else if (k == 5) begin
            start = 1'b0;
         end
         if (done_a) begin
            lat = k;
            break;
         end
      end
      chk("busy_start latency", lat, 11);
      chk("busy_start digits", int'({d3_a, d2_a, d1_a, d0_a}), 16'hA123);
      $display("[TB] busy_start digits=%h%h%h%h", d3_a, d2_a, d1_a, d0_a);

      // Held start: accepted at N+12, done at N+23
      start = 1'b1;
      value = 11'h419;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) chk("held accept busy", int'(busy_a), 1);
         if (done_a) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
      chk("held latency", lat, 12);
      chk_outs("held", 11'h419);
      $display("[TB] held digits=%h%h%h%h", d3_a, d2_a, d1_a, d0_a);

      // Reset mid-conversion
      pulse_start(11'd888);
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst digits_a", int'({d3_a, d2_a, d1_a, d0_a}), 16'hAA00);
      chk("midrst digits_b", int'({d3_b, d2_b, d1_b, d0_b}), 16'hAA00);
      chk("midrst busy", int'(busy_a), 0);
      chk("midrst ovf", int'(ovf_a), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      lat = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (done_a || busy_a) lat++;
      end
      chk("midrst no done/busy", lat, 0);
      $display("[TB] midrst digits=%h%h%h%h", d3_a, d2_a, d1_a, d0_a);
      run_case("post_rst", 11'd888);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bcd_temp_display.md
# bcd_temp_display

Converts a signed binary temperature in tenths of a degree (−99.9 to +99.9) into the four digit codes that drive the team's `seven_seg` decoders. The digit codes are: sign, tens, units and tenths. This is the output-side counterpart of the switch/KEY BCD entry path, which turns keypresses into digits; this block turns a binary value back into displayable digits. Conversion is a sequential double-dabble with a start/busy/done handshake. Digit outputs update atomically when a conversion completes.

## Interface
- `OFF_CODE`, default 4'hA: digit code that blanks a `seven_seg` display.
- `NEG_CODE`, default 4'hB: digit code that displays a minus sign.
- `BLANK_LEAD`, default 1: when 1, a zero tens digit is replaced by `OFF_CODE`.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `value`  in  11: signed two's-complement temperature in tenths of a degree.
- `start`  in  1: request a conversion; sampled only in IDLE.
- `busy`  out  1: conversion in progress.
- `done`  out  1: one-cycle pulse; new digits are valid.
- `ovf`  out  1: last converted `value` had magnitude > 999 and was clamped.
- `digit_0`  out  4: tenths.
- `digit_1`  out  4: units.
- `digit_2`  out  4: tens, or `OFF_CODE`.
- `digit_3`  out  4: sign, either `NEG_CODE` or `OFF_CODE`.

## Operation
- State machine: IDLE, SHIFT, FMT.
- IDLE:
  - If `start`=1, latch `value` into the working register, clear the shift counter, set `busy`=1 and go to SHIFT.
  - `start` is ignored in all other states. `value` is sampled only at this edge.
- Load arithmetic:
  - sign = `value`[10].
  - mag = |`value|`, computed at 11 bits so that −1024 yields 1024.
  - If mag > 999, then mag = 999 and the pending overflow flag = 1.
  - Otherwise mag is unchanged and the pending overflow flag = 0.
  - Working register: 12-bit BCD field (cleared) concatenated with the 10-bit mag.
- SHIFT (exactly 10 cycles):
  - Each cycle, every BCD nibble ≥ 5 gets +3, then the whole 22-bit register shifts left by 1.
  - After the 10th shift, go to FMT.
- FMT (1 cycle):
  - `digit_0` = ones nibble.
  - `digit_1` = tens nibble (this is the units of degrees).
  - `digit_2` = hundreds nibble, or `OFF_CODE` if it is 0 and `BLANK_LEAD`=1.
  - `digit_3` = `NEG_CODE` if sign=1 (a negative value is never 0), else `OFF_CODE`.
  - `ovf` takes the pending flag; `done`=1; `busy`=0; go to IDLE.
- Digit outputs and `ovf` change only at the FMT edge and hold between conversions. They never show intermediate values.
- The tenths and units digits are never blanked, so 0 displays as "0.0".

## Timing
- `start` is sampled high at edge N (state IDLE).
- `busy` is high from after edge N until edge N+11: 11 cycles.
- Shifts occur on edges N+1 … N+10.
- Outputs update and `done` rises at edge N+11; `done` falls at N+12.
- Start-to-done latency: 11 cycles.
- Back-to-back operation:
  - The state is IDLE after edge N+11, so a `start` held high is accepted at N+12.
  - Maximum throughput: one conversion per 12 cycles.
- Reset values, applied immediately on `rst`=0 regardless of clock:
  - state = IDLE, `busy`=0, `done`=0, `ovf`=0.
  - `digit_0`=0, `digit_1`=0, `digit_2`=`OFF_CODE`, `digit_3`=`OFF_CODE`.
- Reset mid-conversion:
  - The conversion is discarded and outputs go to their reset values.
  - No `done` pulse is produced.
  - The first `start` after `rst` is released proceeds normally.

## Test plan
- **Reset, idle:** `rst`=0, then release, no `start` → digits 3..0 = A,A,0,0; `busy`=0, `done`=0, `ovf`=0.
- **Positive value:** `value`=+257, `start` at edge N →
  - `busy` high for 11 cycles;
  - `done` high only during N+11..N+12;
  - digits = A,2,5,7; `ovf`=0;
  - outputs unchanged before N+11.
- **Negative with blanking:** `value`=−45 (11'h7D3) → digits B,A,4,5. Repeat with `BLANK_LEAD`=0 → B,0,4,5.
- **Overflow:**
  - `value`=−1024 → digits B,9,9,9, `ovf`=1.
  - `value`=+1000 → A,9,9,9, `ovf`=1.
  - A following conversion of +5 → A,A,0,5 and `ovf`=0.
- **Start while busy and held start:**
  - Convert +123 and pulse `start` with `value`=−999 at N+5 → the pulse is ignored; result A,1,2,3.
  - Then hold `start`=1 with −999 → a second conversion begins at N+12; `done` at N+23 with B,9,9,9.
- **Reset mid-conversion:**
  - Start +888, assert `rst` at N+6 → outputs immediately A,A,0,0 with `busy`=0, and no `done` pulse.
  - After release, convert +888 → A,8,8,8 after 11 cycles.
